// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, scheduler defaults and state encoding.
// Imported by the TX scheduler, the receiver and the future transmitter.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int DEF_N       = 4;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } sched_state_t;

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Combinational round-robin picker: first asserted request after ptr.
// Shared with the RX-side dispatcher.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    // Scan farthest-first so the nearest candidate after ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int d = N; d >= 1; d--) begin
            cand = IW'((int'(ptr) + d) % N);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between N requesters.
// One byte in flight at a time; watchdog catches a transmitter that never goes busy.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N-1:0]             req,
    input  logic [UART_DATA_W*N-1:0] req_data,
    output logic [N-1:0]             ack,
    input  logic                     tx_busy,
    output logic                     tx_start,
    output logic [UART_DATA_W-1:0]   tx_data,
    output logic [$clog2(N)-1:0]     owner,
    output logic                     sched_busy,
    input  logic                     err_clr,
    output logic                     timeout_err
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT + 1);

    sched_state_t  state;
    logic [IW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic          pick_found;
    logic [IW-1:0] pick_idx;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign sched_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= IW'(N - 1);
            cnt         <= '0;
            ack         <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            owner       <= '0;
            timeout_err <= 1'b0;
        end else begin
            ack      <= '0;
            tx_start <= 1'b0;
            // A timeout in the same cycle overrides this clear below.
            if (err_clr) timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        tx_data       <= req_data[int'(pick_idx)*UART_DATA_W +: UART_DATA_W];
                        owner         <= pick_idx;
                        ack[pick_idx] <= 1'b1;
                        tx_start      <= 1'b1;
                        state         <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        cnt         <= CW'(TIMEOUT);
                        timeout_err <= 1'b1;
                        ptr         <= owner;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        ptr   <= owner;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler with a simple transmitter model
// and a round-robin reference kept as plain arithmetic over the last served index.
module tb_uart_tx_scheduler;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   ack;
    logic           tx_busy;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic [1:0]     owner;
    logic           sched_busy;
    logic           err_clr;
    logic           timeout_err;

    int         total = 0;
    int         bad   = 0;
    int         last;
    logic [7:0] bytes [N];
    logic       tx_en;
    int         tx_delay;
    int         frame_len;

    uart_tx_scheduler #(
        .N       (N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .owner       (owner),
        .sched_busy  (sched_busy),
        .err_clr     (err_clr),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transmitter model: busy goes high tx_delay cycles after a start, for frame_len cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_en && tx_start === 1'b1) begin
                repeat (tx_delay) begin
                    @(posedge clk);
                    #1;
                end
                tx_busy = 1'b1;
                repeat (frame_len) begin
                    @(posedge clk);
                    #1;
                end
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put_byte(input int i, input logic [7:0] b);
        bytes[i] = b;
        req_data[8*i +: 8] = b;
    endtask

    function automatic int model_pick(input logic [N-1:0] m, input int from);
        for (int d = 1; d <= N; d++) begin
            if (m[(from + d) % N]) return (from + d) % N;
        end
        return 0;
    endfunction

    task automatic expect_grant(input string tag, output int idx, output logic [7:0] b);
        int waited;
        waited = 0;
        idx = model_pick(req, last);
        b = bytes[idx];
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                waited = i;
                break;
            end
        end
        chk({tag, " latency"}, waited, 1);
        chk({tag, " ack"}, 32'(ack), 32'(1) << idx);
        chk({tag, " tx_start"}, tx_start, 1);
        chk({tag, " tx_data"}, tx_data, b);
        chk({tag, " owner"}, owner, idx);
        chk({tag, " busy_at_ack"}, tx_busy, 0);
        last = idx;
    endtask

    task automatic finish_frame(input string tag, input logic [7:0] b);
        int n;
        n = 0;
        while (tx_busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " busy_rise"}, tx_busy, 1);
        n = 0;
        while (tx_busy === 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " busy_fall"}, tx_busy, 0);
        chk({tag, " data_held"}, tx_data, b);
        chk({tag, " sched_busy_hold"}, sched_busy, 1);
        chk({tag, " no_ack_in_frame"}, ack, 0);
        @(negedge clk);
        chk({tag, " sched_busy_fall"}, sched_busy, 0);
        chk({tag, " no_early_ack"}, ack, 0);
    endtask

    initial begin
        int         idx;
        int         n;
        logic [7:0] b;
        logic       anyack;

        reset     = 1'b0;
        req       = '1;
        req_data  = '0;
        err_clr   = 1'b0;
        tx_en     = 1'b1;
        tx_delay  = 2;
        frame_len = 10;
        last      = N - 1;
        for (int i = 0; i < N; i++) put_byte(i, 8'($urandom));

        repeat (2) @(negedge clk);
        chk("reset ack", ack, 0);
        chk("reset tx_start", tx_start, 0);
        chk("reset tx_data", tx_data, 0);
        chk("reset owner", owner, 0);
        chk("reset sched_busy", sched_busy, 0);
        chk("reset timeout_err", timeout_err, 0);
        reset = 1'b1;

        for (int k = 0; k < 8; k++) begin
            expect_grant("fair", idx, b);
            chk("fair order", owner, k % N);
            put_byte(idx, 8'($urandom));
            finish_frame("fair", b);
        end

        req = 4'b0100;
        put_byte(2, 8'hA5);
        expect_grant("single", idx, b);
        req = '0;
        finish_frame("single", 8'hA5);

        for (int r = 0; r < 8; r++) begin
            tx_delay  = $urandom_range(1, 3);
            frame_len = $urandom_range(2, 12);
            for (int i = 0; i < N; i++) put_byte(i, 8'($urandom));
            req = 4'($urandom_range(1, 15));
            expect_grant("rand", idx, b);
            req = '0;
            finish_frame("rand", b);
        end

        tx_en = 1'b0;
        req = 4'b0001;
        expect_grant("wd1", idx, b);
        req = '0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (timeout_err === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("wd1 err_latency", n, TIMEOUT + 1);
        chk("wd1 idle", sched_busy, 0);

        req = 4'b0010;
        expect_grant("wd2", idx, b);
        req = '0;
        @(negedge clk);
        chk("wd2 sticky", timeout_err, 1);
        repeat (TIMEOUT - 1) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("wd2 set_wins", timeout_err, 1);
        chk("wd2 idle", sched_busy, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("wd clear", timeout_err, 0);

        tx_en     = 1'b1;
        tx_delay  = 2;
        frame_len = 20;
        req = '1;
        expect_grant("rst", idx, b);
        req = '0;
        n = 0;
        while (tx_busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst ack", ack, 0);
        chk("rst tx_start", tx_start, 0);
        chk("rst tx_data", tx_data, 0);
        chk("rst owner", owner, 0);
        chk("rst sched_busy", sched_busy, 0);
        chk("rst timeout_err", timeout_err, 0);
        anyack = 1'b0;
        n = 0;
        while (tx_busy === 1'b1 && n < 40) begin
            @(negedge clk);
            if (ack != '0) anyack = 1'b1;
            n++;
        end
        chk("rst no_reack", anyack, 0);
        last = N - 1;
        reset = 1'b1;
        req = '1;
        expect_grant("rst prio", idx, b);
        chk("rst prio owner", owner, 0);
        req = '0;
        finish_frame("rst prio", b);

        tx_delay  = 1;
        frame_len = 3;
        req = 4'b1000;
        expect_grant("fast", idx, b);
        req = '0;
        finish_frame("fast", b);
        chk("fast no_err", timeout_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one UART transmitter between `N` byte-producing requesters. It accepts a byte from one requester at a time and launches it on the transmitter with a one-cycle start strobe. It then follows the transmitter's busy flag until the frame completes, and only then serves the next requester. It sits between the protocol clients and the transmitter, which is the sibling of the existing receiver. A watchdog flags a transmitter that never acknowledges a start.

## Interface
Parameters:
- `N`, 4: number of requesters (2..8).
- `TIMEOUT`, 16: maximum cycles in WAIT_BUSY waiting for `tx_busy` to rise (≥2).

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low; `reset==0` at a rising edge resets all state.
- `req`  in  N  per-requester byte-valid; held high with data stable until `ack`.
- `req_data`  in  8*N  byte of requester i at bits `[8*i+7:8*i]`.
- `ack`  out  N  one-hot, one-cycle pulse: byte of requester i taken.
- `tx_busy`  in  1  transmitter frame-in-progress flag.
- `tx_start`  out  1  one-cycle launch strobe to transmitter.
- `tx_data`  out  8  byte for transmitter, stable from `tx_start` until the frame ends.
- `owner`  out  $clog2(N)  index of requester currently served.
- `sched_busy`  out  1  high in any state other than IDLE.
- `err_clr`  in  1  clears `timeout_err`.
- `timeout_err`  out  1  sticky watchdog error.

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE: if `req != 0`, pick the first asserted requester scanning `ptr+1, ptr+2, …` modulo N.
  - Latch its byte into `tx_data` and its index into `owner`.
  - Pulse `ack[owner]` and go to LAUNCH.
  - `req` is sampled only in IDLE.
- LAUNCH: `tx_start=1` for exactly this cycle. Clear the watchdog counter and go to WAIT_BUSY.
- WAIT_BUSY:
  - `tx_busy=1` → go to WAIT_DONE.
  - Otherwise, increment the counter. If it reaches `TIMEOUT`, set `timeout_err`, set `ptr=owner`, and go to IDLE. The byte is lost.
- WAIT_DONE: on `tx_busy=0`, set `ptr=owner` and go to IDLE.
- `ptr` resets to N-1, so requester 0 wins first after reset.
- `sched_busy = (state != IDLE)`.
- `timeout_err`:
  - set on timeout, cleared by `err_clr`;
  - if both occur in the same cycle, set wins.
- Watchdog counter is $clog2(TIMEOUT+1) bits, unsigned, and never wraps.
- `req_data` of non-selected requesters is ignored.
- A requester that drops `req` before `ack` simply loses arbitration.

## Timing
- Reset values:
  - `ack=0`, `tx_start=0`, `tx_data=8'h00`, `owner=0`;
  - `sched_busy=0`, `timeout_err=0`;
  - state IDLE, `ptr=N-1`, counter 0.
- Request seen in IDLE at edge k:
  - `ack`, `tx_data`, `owner` valid and `tx_start=1` from edge k+1, for one cycle;
  - WAIT_BUSY from edge k+2.
- `ack` and `tx_start` are always coincident and always single-cycle.
- `ack` is registered; requesters may present the next byte in the cycle after `ack`.
- After `tx_busy` falls at edge m: IDLE at edge m+1; the next `ack`/`tx_start` is no earlier than edge m+2.
  - Minimum issue spacing is frame time + 3 cycles.
- If `tx_busy` is already 1 on the first WAIT_BUSY cycle, that counts; proceed to WAIT_DONE at the next edge.
- Timeout: with `tx_busy` held 0, `timeout_err` rises `TIMEOUT` cycles after WAIT_BUSY entry, in the same cycle as the return to IDLE.
- Reset asserted mid-frame:
  - all outputs return to reset values at that edge and any in-flight byte is abandoned;
  - `ack` already given is not repeated.
- All outputs are registered or decoded from registered state; no combinational path from `req` to any output.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE);
  - `UART_DATA_W=8`;
  - default `N` and `TIMEOUT` constants.
  - The receiver and future transmitter also import it.
- One natural sub-module: `rr_pick`, a combinational round-robin picker.
  - Inputs: `req`, `ptr`.
  - Outputs: `found`, `idx`.
  - Reusable for the later RX-side dispatcher.

## Test plan
- Reset with `reset=0` for 2 cycles and `req=4'b1111`: all outputs at reset values. After release, first `ack=4'b0001` and `tx_data` = byte 0.
- Single request: requester 2 sends `8'hA5` with a transmitter model busy 10 cycles. Expect `ack[2]` and `tx_start` together one edge after `req`, `tx_data=8'hA5` held through busy, `sched_busy` falling one cycle after `tx_busy` falls.
- Fairness: `req=4'b1111` held continuously for 8 transfers. Expect ack order 0,1,2,3,0,1,2,3 with no `ack` while `tx_busy=1`.
- Watchdog: `tx_busy` tied 0, `TIMEOUT=16`, one request. Expect `timeout_err=1` 16 cycles after WAIT_BUSY entry and the next request served.
  - `err_clr` pulsed together with a second timeout leaves `timeout_err=1`.
- Reset mid-frame: assert `reset=0` during WAIT_DONE with `tx_busy=1`. Expect IDLE, `tx_start=0`, `tx_data=8'h00`, and no repeated `ack`. After release, requester 0 has priority again.
- Fast busy: `tx_busy` already 1 when WAIT_BUSY is entered. Expect WAIT_DONE next edge, no watchdog increment beyond 1, and `timeout_err` stays 0.
